// File: rtl/smvm_pkg.sv
// smvm_pkg: state encodings and the input credit rule shared by smvm_stream.
package smvm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VEC   = 2'd1,
    ST_MAT   = 2'd2,
    ST_DRAIN = 2'd3
  } smvm_state_e;

  // A new beat may enter only if every beat already in flight keeps k reserved FIFO slots.
  function automatic logic credit_ok(input int depth, input int used, input int k, input int inflight);
    return (depth - used - k * inflight) >= k;
  endfunction

endpackage

// File: rtl/smvm_out_fifo.sv
// smvm_out_fifo: result FIFO taking up to NPUSH lane-ordered pushes and one pop per cycle.
// Zero-latency head; push_vld must be contiguous from bit 0 and never exceed free space.
module smvm_out_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 16,
  parameter int NPUSH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NPUSH-1:0]             push_vld,
  input  logic [NPUSH*W-1:0]           push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int AWID = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem [DEPTH];
  logic [AWID-1:0] wptr;
  logic [AWID-1:0] rptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   npush;
  logic            pop_en;

  always_comb begin
    npush = '0;
    for (int i = 0; i < NPUSH; i++) begin
      npush = npush + CW'(push_vld[i]);
    end
  end

  assign pop_en = pop && (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPUSH; i++) begin
        if (push_vld[i]) begin
          mem[wptr + AWID'(i)] <= push_dat[i*W +: W];
        end
      end
      wptr <= wptr + AWID'(npush);
      if (pop_en) begin
        rptr <= rptr + AWID'(1);
      end
      cnt <= cnt + npush - CW'(pop_en);
    end
  end

  assign head  = mem[rptr];
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/smvm_stream.sv
// smvm_stream: streaming sparse matrix-vector multiply; beat->FIFO in 2 cycles, FIFO credits gate in_ready.
// Optional SMVM_SAT_EN: wide internal accumulator with saturated row results instead of OW-bit wrap.
module smvm_stream import smvm_pkg::*; #(
  parameter int K          = 4,
  parameter int DW         = 8,
  parameter int MAX_COLS   = 256,
  parameter int CIW        = 8,
  parameter int OW         = 20,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [15:0]       cfg_rows,
  input  logic [CIW:0]      cfg_cols,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K*DW-1:0]   in_data,
  input  logic [K*CIW-1:0]  in_col,
  input  logic [K-1:0]      in_eor,
  input  logic [K-1:0]      in_lmask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     out_data,
  output logic              done,
  output logic              col_err
);

`ifdef SMVM_SAT_EN
  localparam int AW = OW + CIW + 1;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
`else
  localparam int AW = OW;
`endif
  localparam int PW = 2 * DW;
  localparam int WA = CIW + 2;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  smvm_state_e state, state_nxt;

  logic [15:0]  rows_q;
  logic [CIW:0] cols_q;
  logic [CIW:0] wptr;
  logic [15:0]  row_cnt;
  logic signed [DW-1:0] vec [MAX_COLS];

  logic              s0_vld;
  logic [K*DW-1:0]   s0_data;
  logic [K*CIW-1:0]  s0_col;
  logic [K-1:0]      s0_eor;
  logic [K-1:0]      s0_lmask;
  logic              s1_vld;
  logic signed [AW-1:0] s1_prod [K];
  logic [K-1:0]      s1_eor;
  logic signed [AW-1:0] carry;

  logic              cfg_fire, vec_fire, mat_fire;
  logic [WA-1:0]     vcnt, wnext;
  logic [WA-1:0]     vwr_full [K];
  logic [CIW-1:0]    vwr_addr [K];
  logic [K-1:0]      vwr_en;

  logic [CIW-1:0]    col_l [K];
  logic signed [PW-1:0] pfull [K];
  logic signed [AW-1:0] prod [K];
  logic [K-1:0]      lane_err;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] carry_nxt;
  logic [15:0]       rc, row_cnt_nxt;
  int                np;
  logic [K-1:0]      push_vld;
  logic [K*OW-1:0]   push_dat;

  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic              room;

  function automatic logic [OW-1:0] to_out(input logic signed [AW-1:0] v);
`ifdef SMVM_SAT_EN
    if (v > SAT_MAX) return SAT_MAX[OW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[OW-1:0];
    else return v[OW-1:0];
`else
    return v;
`endif
  endfunction

  assign room     = credit_ok(FIFO_DEPTH, int'(fifo_cnt), K, int'(s0_vld) + int'(s1_vld));
  assign cfg_fire = (state == ST_IDLE) && cfg_valid;
  assign vec_fire = (state == ST_VEC) && in_valid;
  assign mat_fire = (state == ST_MAT) && in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_nxt = ST_VEC;
      end
      ST_VEC: begin
        in_ready = 1'b1;
        if (in_valid && (wnext >= {1'b0, cols_q})) state_nxt = ST_MAT;
      end
      ST_MAT: begin
        in_ready = room;
        if (s1_vld && (row_cnt_nxt >= rows_q)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty && !s0_vld && !s1_vld) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Vector load: lanes past cfg_cols are dropped, the pointer still advances by popcount.
  always_comb begin
    vcnt   = '0;
    vwr_en = '0;
    for (int i = 0; i < K; i++) begin
      vwr_full[i] = {1'b0, wptr} + WA'(i);
      vwr_addr[i] = vwr_full[i][CIW-1:0];
      vwr_en[i]   = in_lmask[i] && (vwr_full[i] < {1'b0, cols_q});
      vcnt        = vcnt + WA'(in_lmask[i]);
    end
    wnext = {1'b0, wptr} + vcnt;
  end

  always_comb begin
    lane_err = '0;
    for (int i = 0; i < K; i++) begin
      col_l[i]    = s0_col[i*CIW +: CIW];
      pfull[i]    = PW'(vec[col_l[i]]) * PW'($signed(s0_data[i*DW +: DW]));
      lane_err[i] = s0_vld && s0_lmask[i] && ({1'b0, col_l[i]} >= cols_q);
      prod[i]     = (s0_lmask[i] && !lane_err[i]) ? AW'(pfull[i]) : '0;
    end
  end

  // Segment sum in lane order; eor lanes past the job's row count are swallowed.
  always_comb begin
    acc      = carry;
    rc       = row_cnt;
    np       = 0;
    push_vld = '0;
    push_dat = '0;
    if (s1_vld) begin
      for (int i = 0; i < K; i++) begin
        acc = acc + s1_prod[i];
        if (s1_eor[i]) begin
          if (rc < rows_q) begin
            for (int j = 0; j < K; j++) begin
              if (j == np) begin
                push_vld[j]           = 1'b1;
                push_dat[j*OW +: OW]  = to_out(acc);
              end
            end
            np = np + 1;
            rc = rc + 16'd1;
          end
          acc = '0;
        end
      end
    end
    carry_nxt   = acc;
    row_cnt_nxt = rc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_COLS; i++) begin
        vec[i] <= '0;
      end
    end else if (vec_fire) begin
      for (int i = 0; i < K; i++) begin
        if (vwr_en[i]) vec[vwr_addr[i]] <= $signed(in_data[i*DW +: DW]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rows_q   <= '0;
      cols_q   <= '0;
      wptr     <= '0;
      row_cnt  <= '0;
      col_err  <= 1'b0;
      carry    <= '0;
      s0_vld   <= 1'b0;
      s0_data  <= '0;
      s0_col   <= '0;
      s0_eor   <= '0;
      s0_lmask <= '0;
      s1_vld   <= 1'b0;
      s1_eor   <= '0;
      for (int i = 0; i < K; i++) begin
        s1_prod[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (cfg_fire) begin
        rows_q  <= cfg_rows;
        cols_q  <= cfg_cols;
        wptr    <= '0;
        row_cnt <= '0;
        carry   <= '0;
        col_err <= 1'b0;
      end
      if (vec_fire) wptr <= wnext[CIW:0];
      s0_vld <= mat_fire;
      if (mat_fire) begin
        s0_data  <= in_data;
        s0_col   <= in_col;
        s0_eor   <= in_eor;
        s0_lmask <= in_lmask;
      end
      s1_vld <= s0_vld;
      if (s0_vld) begin
        s1_prod <= prod;
        s1_eor  <= s0_eor & s0_lmask;
        if (|lane_err) col_err <= 1'b1;
      end
      if (s1_vld) begin
        carry   <= carry_nxt;
        row_cnt <= row_cnt_nxt;
      end
    end
  end

  smvm_out_fifo #(
    .W     (OW),
    .DEPTH (FIFO_DEPTH),
    .NPUSH (K)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop      (out_valid && out_ready),
    .head     (out_data),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign out_valid = !fifo_empty;

endmodule
